piece_drop: RTL

Active-piece engine that sits directly upstream of clear_redraw. It spawns the current piece at the top of the 32-bit board and moves it left or right on request. It drops the piece on a gravity tick or a soft drop, locks it into the board on collision, and hands the locked board and piece type to clear_redraw. It then waits for the cleared board to come back before spawning the next piece.

---
 rtl/piece_drop.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/piece_drop.sv
// Active-piece engine: spawns a piece, shifts and drops it, locks it into the 8x4 board
// and hands the locked board to clear_redraw, then waits for the cleared board back.
module piece_drop #(
    parameter int GRAV_DIV  = 4,
    parameter int SPAWN_COL = 1
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        start,
    input  logic [1:0]  piece_in,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        soft_drop,
    input  logic [31:0] clr_board,
    input  logic        clr_valid,
    output logic [31:0] board_out,
    output logic [1:0]  curr_piece,
    output logic        out_valid,
    output logic [31:0] display,
    output logic [2:0]  state,
    output logic        error
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SPAWN   = 3'd1;
    localparam logic [2:0] S_FALL    = 3'd2;
    localparam logic [2:0] S_LOCK    = 3'd3;
    localparam logic [2:0] S_HANDOFF = 3'd4;
    localparam logic [2:0] S_OVER    = 3'd5;
    localparam logic [7:0] CNT_MAX   = 8'(GRAV_DIV - 1);
    localparam logic [1:0] COL0      = 2'(SPAWN_COL);

    // Type bit 0 widens the piece to two columns, bit 1 makes it two rows tall.
    function automatic logic [31:0] piece_mask(input logic [1:0] typ, input logic [3:0] row,
                                               input logic [1:0] col);
        logic [3:0]  rp;
        logic [31:0] m;
        rp = (typ[0] ? 4'b0011 : 4'b0001) << col;
        m  = {28'b0, rp} << {row, 2'b00};
        if (typ[1]) m = m | ({28'b0, rp} << {row + 4'd1, 2'b00});
        return m;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] board_q, board_d;
    logic [31:0] board_out_q, board_out_d;
    logic [1:0]  curr_piece_q, curr_piece_d;
    logic        out_valid_q, out_valid_d;
    logic        error_q, error_d;
    logic [1:0]  type_q, type_d;
    logic [2:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] mask, spawn_mask;
    logic [2:0]  spawn_row;
    logic [1:0]  col_max;
    logic        tick;

    assign mask       = piece_mask(type_q, {1'b0, row_q}, col_q);
    assign spawn_row  = piece_in[1] ? 3'd6 : 3'd7;
    assign spawn_mask = piece_mask(piece_in, {1'b0, spawn_row}, COL0);
    assign col_max    = type_q[0] ? 2'd2 : 2'd3;
    assign tick       = (cnt_q == CNT_MAX) || soft_drop;

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            board_out_q  <= '0;
            curr_piece_q <= '0;
            out_valid_q  <= 1'b0;
            error_q      <= 1'b0;
            type_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            board_out_q  <= board_out_d;
            curr_piece_q <= curr_piece_d;
            out_valid_q  <= out_valid_d;
            error_q      <= error_d;
            type_q       <= type_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        board_out_d  = board_out_q;
        curr_piece_d = curr_piece_q;
        out_valid_d  = out_valid_q;
        error_d      = error_q;
        type_d       = type_q;
        row_d        = row_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SPAWN;
            S_SPAWN: begin
                type_d = piece_in;
                row_d  = spawn_row;
                col_d  = COL0;
                cnt_d  = '0;
                if (|(spawn_mask & board_q)) begin
                    state_d = S_OVER;
                    error_d = 1'b1;
                end else begin
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (tick) begin
                    cnt_d = '0;
                    if (row_q != 3'd0 && !(|((mask >> 4) & board_q))) row_d = row_q - 3'd1;
                    else state_d = S_LOCK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Row-internal shifts cannot wrap because of the column bound checks.
                    if (move_left && !move_right) begin
                        if (col_q != 2'd0 && !(|((mask >> 1) & board_q))) col_d = col_q - 2'd1;
                    end else if (move_right && !move_left) begin
                        if (col_q < col_max && !(|((mask << 1) & board_q))) col_d = col_q + 2'd1;
                    end
                end
            end
            S_LOCK: begin
                board_d      = board_q | mask;
                board_out_d  = board_q | mask;
                curr_piece_d = type_q;
                out_valid_d  = 1'b1;
                state_d      = S_HANDOFF;
            end
            S_HANDOFF: if (clr_valid) begin
                board_d     = clr_board;
                out_valid_d = 1'b0;
                state_d     = S_SPAWN;
            end
            S_OVER: begin
                out_valid_d = 1'b0;
                error_d     = 1'b1;
                if (start) begin
                    board_d = '0;
                    error_d = 1'b0;
                    state_d = S_SPAWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        display = board_q;
        if (state_q == S_FALL) display = board_q | mask;
        else if (state_q == S_IDLE) display = '0;
    end

    assign board_out  = board_out_q;
    assign curr_piece = curr_piece_q;
    assign out_valid  = out_valid_q;
    assign state      = state_q;
    assign error      = error_q;
endmodule
